dcache_tag_arbiter_mp: RTL and testbench
========================================

Name: dcache_tag_arbiter_mp

Overview:
- Parametrised multi-port arbiter and tag/state store for the std L1 dcache. Generalises the fixed 5-port tag compare path.
- Arbitrates NR_PORTS requesters onto one tag SRAM per way plus a flop-based valid/dirty/shared array.
- Returns registered per-way tags, states and hit-way one cycle after grant.
- Adds two behaviours the current path lacks: hybrid fixed-priority/round-robin arbitration, and a hardware invalidate-all sweep that also runs automatically out of reset.

Parameters:
NR_PORTS, 5, number of requesters (2..8)
PRIO_PORTS, 2, ports [0..PRIO_PORTS-1] use fixed priority (lowest index wins); the remaining ports use round-robin
NR_WAYS, 8, associativity (power of two)
SET_IDX_W, 8, set index width; NUM_SETS = 2**SET_IDX_W
TAG_W, 44, tag width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  NR_PORTS  per-port request, level
we_i  in  NR_PORTS  per-port write
set_i  in  NR_PORTS*SET_IDX_W  set index
way_we_i  in  NR_PORTS*NR_WAYS  ways written on a write
wtag_i  in  NR_PORTS*TAG_W  write tag
wstate_i  in  NR_PORTS*3  write state {shared,dirty,valid}
cmp_tag_i  in  NR_PORTS*TAG_W  compare tag (reads)
gnt_o  out  NR_PORTS  one-hot grant, combinational
rvalid_o  out  NR_PORTS  one-hot; read result valid for this port
rtag_o  out  NR_WAYS*TAG_W  per-way tag read
rstate_o  out  NR_WAYS*3  per-way state read
hit_way_o  out  NR_WAYS  valid && tag match, per way
hit_o  out  1  OR of hit_way_o
multi_hit_o  out  1  more than one bit of hit_way_o set
inv_all_i  in  1  start invalidate-all sweep (pulse or level)
inv_busy_o  out  1  sweep in progress
inv_done_o  out  1  one-cycle pulse on sweep completion

Behaviour:
- Reset values: rst_i forces state SWEEP, counter = 0, rr_ptr = PRIO_PORTS. All other outputs 0 except inv_busy_o = 1.
- FSM states: IDLE and SWEEP.
  - SWEEP: every cycle writes state 3'b000 to all ways of set counter. gnt_o = 0.
  - On counter == NUM_SETS-1: inv_done_o = 1 that cycle, next state IDLE, counter wraps to 0.
  - A sweep takes exactly NUM_SETS cycles.
  - inv_all_i is ignored while in SWEEP. Nothing can be written during a sweep, so the result is unaffected.
  - IDLE with inv_all_i = 1: next state SWEEP, and no grant is issued that cycle.
  - rst_i asserted mid-sweep restarts the sweep from set 0.
  - A sweep discards dirty data. Callers must flush before issuing inv_all_i.
- Arbitration (IDLE only), cycle 0:
  - If any port < PRIO_PORTS requests, the lowest such index wins.
  - Otherwise round-robin among ports >= PRIO_PORTS, starting at rr_ptr. On a round-robin grant, rr_ptr moves to the winner+1, wrapping from NR_PORTS-1 to PRIO_PORTS.
  - A fixed-priority grant leaves rr_ptr unchanged.
  - A requester holds req_i and its operands until it sees gnt_o.
  - If PRIO_PORTS == NR_PORTS, round-robin is disabled.
- Write (granted with we_i = 1):
  - Tag SRAM and state are written for ways with way_we_i set, at the cycle-0 edge.
  - rvalid_o is not asserted for writes.
- Read (granted with we_i = 0):
  - Set and cmp_tag are registered.
  - Cycle 1: rvalid_o[port] = 1 together with rtag_o, rstate_o, hit_way_o, hit_o and multi_hit_o.
  - hit_way_o[w] = rstate[w].valid && rtag[w] == registered cmp_tag.
- Read-after-write: a write at cycle N followed by a read of the same set at N+1 returns the new tag and state.
- Back-to-back grants are allowed every cycle. Outputs other than rvalid_o are don't-care when rvalid_o == 0.

Decomposition:
- Shared package std_cache_pkg gains:
  - line_state_t {shared, dirty, valid}
  - constants DCACHE_STATE_W = 3 and a default NR_PORTS
- Sub-module tag_arb_hybrid: the priority/round-robin arbiter with rr_ptr.
- Tag storage reuses the existing sram, one instance per way.
- State is a flop array NUM_SETS x NR_WAYS x 3 inside this block. Flops allow clearing one full set per cycle.

Test Plan:
- Reset released at cycle 0 -> inv_busy_o = 1 for 256 cycles, inv_done_o pulse at cycle 255, gnt_o = 0 throughout; then reads of every set return rstate_o = 0 and hit_o = 0.
- Ports 0, 1, 3 request together -> gnt_o = 5'b00001; with port 0 dropped -> 5'b00010; with ports 2, 3, 4 requesting continuously -> grants rotate 2, 3, 4, 2.
- Port 2 writes set 0x15, way 3, tag 0xABC, state valid; next cycle port 4 reads set 0x15 with cmp 0xABC -> rvalid_o = 5'b10000, hit_way_o = 8'b00001000, multi_hit_o = 0.
- Same tag written valid in ways 1 and 5 of set 7, then a read -> hit_way_o = 8'b00100010, multi_hit_o = 1.
- inv_all_i pulse during continuous requests -> no gnt_o for 256 cycles, then the previous hit set reads hit_o = 0.
- rst_i asserted at sweep counter 100 -> sweep restarts at 0, completes 256 cycles after reset deassertion, exactly one inv_done_o pulse.

Source files
------------

// File: rtl/std_cache_pkg.sv
// Shared L1 dcache types and constants: line state encoding and port defaults.
package std_cache_pkg;

   localparam int unsigned DCACHE_STATE_W  = 3;
   localparam int unsigned DCACHE_NR_PORTS = 5;

   typedef struct packed {
      logic shared;
      logic dirty;
      logic valid;
   } line_state_t;

   // True when more than one bit of a hit vector is set.
   function automatic logic more_than_one(input logic [31:0] v);
      return (v & (v - 32'd1)) != 32'd0;
   endfunction

endpackage

// File: rtl/sram.sv
// Single-port synchronous SRAM model: write on req&we, registered read data.
module sram #(
   parameter int unsigned DATA_W    = 44,
   parameter int unsigned NUM_WORDS = 256
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         req_i,
   input  logic                         we_i,
   input  logic [$clog2(NUM_WORDS)-1:0] addr_i,
   input  logic [DATA_W-1:0]            wdata_i,
   output logic [DATA_W-1:0]            rdata_o
);

   logic [DATA_W-1:0] mem [NUM_WORDS];

   always_ff @(posedge clk_i) begin
      if (req_i && we_i) mem[addr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)               rdata_o <= '0;
      else if (req_i && !we_i) rdata_o <= mem[addr_i];
   end

endmodule

// File: rtl/tag_arb_hybrid.sv
// Hybrid arbiter: low ports fixed priority, remaining ports round-robin from rr_ptr.
module tag_arb_hybrid #(
   parameter int unsigned NR_PORTS   = 5,
   parameter int unsigned PRIO_PORTS = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic [NR_PORTS-1:0] req_i,
   output logic [NR_PORTS-1:0] gnt_o
);

   localparam int unsigned NR_RR = NR_PORTS - PRIO_PORTS;
   localparam int unsigned IDX_W = $clog2(NR_PORTS);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] rr_next;
   logic [IDX_W-1:0] idx;
   logic             rr_hit;
   logic             found;
   int unsigned      pos;

   always_comb begin
      gnt_o   = '0;
      rr_next = rr_ptr;
      rr_hit  = 1'b0;
      found   = 1'b0;
      idx     = '0;
      pos     = 0;
      if (en_i) begin
         for (int unsigned i = 0; i < PRIO_PORTS; i++) begin
            if (!found && req_i[IDX_W'(i)]) begin
               gnt_o[IDX_W'(i)] = 1'b1;
               found            = 1'b1;
            end
         end
         // Scan the round-robin group starting at rr_ptr, wrapping back to PRIO_PORTS.
         for (int unsigned i = 0; i < NR_RR; i++) begin
            pos = 32'(rr_ptr) + i;
            if (pos >= NR_PORTS) pos = pos - NR_RR;
            idx = IDX_W'(pos);
            if (!found && req_i[idx]) begin
               gnt_o[idx] = 1'b1;
               found      = 1'b1;
               rr_hit     = 1'b1;
               rr_next    = (idx == IDX_W'(NR_PORTS - 1)) ? IDX_W'(PRIO_PORTS) : idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)       rr_ptr <= IDX_W'(PRIO_PORTS);
      else if (rr_hit) rr_ptr <= rr_next;
   end

endmodule

// File: rtl/dcache_tag_arbiter_mp.sv
// Multi-port dcache tag/state store: hybrid arbitration onto per-way tag SRAMs and a
// flop state array, with an invalidate-all sweep that also runs out of reset.
module dcache_tag_arbiter_mp
   import std_cache_pkg::*;
#(
   parameter int unsigned NR_PORTS   = DCACHE_NR_PORTS,
   parameter int unsigned PRIO_PORTS = 2,
   parameter int unsigned NR_WAYS    = 8,
   parameter int unsigned SET_IDX_W  = 8,
   parameter int unsigned TAG_W      = 44
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NR_PORTS-1:0]                 req_i,
   input  logic [NR_PORTS-1:0]                 we_i,
   input  logic [NR_PORTS*SET_IDX_W-1:0]       set_i,
   input  logic [NR_PORTS*NR_WAYS-1:0]         way_we_i,
   input  logic [NR_PORTS*TAG_W-1:0]           wtag_i,
   input  logic [NR_PORTS*DCACHE_STATE_W-1:0]  wstate_i,
   input  logic [NR_PORTS*TAG_W-1:0]           cmp_tag_i,
   output logic [NR_PORTS-1:0]                 gnt_o,
   output logic [NR_PORTS-1:0]                 rvalid_o,
   output logic [NR_WAYS*TAG_W-1:0]            rtag_o,
   output logic [NR_WAYS*DCACHE_STATE_W-1:0]   rstate_o,
   output logic [NR_WAYS-1:0]                  hit_way_o,
   output logic                                hit_o,
   output logic                                multi_hit_o,
   input  logic                                inv_all_i,
   output logic                                inv_busy_o,
   output logic                                inv_done_o
);

   localparam int unsigned NUM_SETS = 2**SET_IDX_W;
   localparam int unsigned SW       = DCACHE_STATE_W;

   typedef enum logic {IDLE, SWEEP} fsm_e;

   fsm_e                 state;
   logic [SET_IDX_W-1:0] counter;

   line_state_t          st_q [NUM_SETS][NR_WAYS];
   line_state_t          rstate_q [NR_WAYS];
   logic [TAG_W-1:0]     cmp_q;
   logic [NR_PORTS-1:0]  rvalid_q;

   logic                 any_gnt;
   logic                 sel_we;
   logic [SET_IDX_W-1:0] sel_set;
   logic [NR_WAYS-1:0]   sel_way_we;
   logic [TAG_W-1:0]     sel_wtag;
   line_state_t          sel_wstate;
   logic [TAG_W-1:0]     sel_cmp;
   logic [NR_WAYS-1:0]   tag_req;

   tag_arb_hybrid #(
      .NR_PORTS   (NR_PORTS),
      .PRIO_PORTS (PRIO_PORTS)
   ) i_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  ((state == IDLE) && !inv_all_i),
      .req_i (req_i),
      .gnt_o (gnt_o)
   );

   // Operand mux for the (one-hot) granted port.
   always_comb begin
      any_gnt    = |gnt_o;
      sel_we     = 1'b0;
      sel_set    = '0;
      sel_way_we = '0;
      sel_wtag   = '0;
      sel_wstate = '0;
      sel_cmp    = '0;
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
         if (gnt_o[p]) begin
            sel_we     = we_i[p];
            sel_set    = set_i[p*SET_IDX_W +: SET_IDX_W];
            sel_way_we = way_we_i[p*NR_WAYS +: NR_WAYS];
            sel_wtag   = wtag_i[p*TAG_W +: TAG_W];
            sel_wstate = line_state_t'(wstate_i[p*SW +: SW]);
            sel_cmp    = cmp_tag_i[p*TAG_W +: TAG_W];
         end
      end
   end

   for (genvar w = 0; w < NR_WAYS; w++) begin : g_way
      assign tag_req[w] = any_gnt && (!sel_we || sel_way_we[w]);

      sram #(
         .DATA_W    (TAG_W),
         .NUM_WORDS (NUM_SETS)
      ) i_tag_sram (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .req_i   (tag_req[w]),
         .we_i    (sel_we),
         .addr_i  (sel_set),
         .wdata_i (sel_wtag),
         .rdata_o (rtag_o[w*TAG_W +: TAG_W])
      );

      assign rstate_o[w*SW +: SW] = rstate_q[w];
      assign hit_way_o[w]         = rstate_q[w].valid && (rtag_o[w*TAG_W +: TAG_W] == cmp_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= SWEEP;
         counter <= '0;
      end else begin
         case (state)
            SWEEP: begin
               counter <= counter + 1'b1;
               if (counter == SET_IDX_W'(NUM_SETS - 1)) state <= IDLE;
            end
            default: begin
               if (inv_all_i) state <= SWEEP;
            end
         endcase
      end
   end

   // State array: sweep clears one full set per cycle, otherwise granted writes.
   always_ff @(posedge clk_i) begin
      if (state == SWEEP) begin
         for (int unsigned w = 0; w < NR_WAYS; w++) st_q[counter][w] <= '0;
      end else if (any_gnt && sel_we) begin
         for (int unsigned w = 0; w < NR_WAYS; w++) begin
            if (sel_way_we[w]) st_q[sel_set][w] <= sel_wstate;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= '0;
         cmp_q    <= '0;
         for (int unsigned w = 0; w < NR_WAYS; w++) rstate_q[w] <= '0;
      end else begin
         rvalid_q <= (any_gnt && !sel_we) ? gnt_o : '0;
         if (any_gnt && !sel_we) begin
            cmp_q <= sel_cmp;
            for (int unsigned w = 0; w < NR_WAYS; w++) rstate_q[w] <= st_q[sel_set][w];
         end
      end
   end

   assign rvalid_o    = rvalid_q;
   assign hit_o       = |hit_way_o;
   assign multi_hit_o = more_than_one(32'(hit_way_o));
   assign inv_busy_o  = (state == SWEEP);
   assign inv_done_o  = (state == SWEEP) && (counter == SET_IDX_W'(NUM_SETS - 1));

endmodule

// File: tb/tb_dcache_tag_arbiter_mp.sv
// Scoreboard bench: random multi-port traffic against a set/way array model with sweep timing.
module tb_dcache_tag_arbiter_mp;

   localparam int NP    = 5;
   localparam int PRIO  = 2;
   localparam int NW    = 8;
   localparam int SW    = 8;
   localparam int TW    = 44;
   localparam int NSETS = 256;

   logic            clk = 1'b0;
   logic            rst;
   logic [NP-1:0]   req, we;
   logic [NP*SW-1:0] set_v;
   logic [NP*NW-1:0] way_we;
   logic [NP*TW-1:0] wtag, cmp;
   logic [NP*3-1:0] wstate;
   logic            inv_all;
   logic [NP-1:0]   gnt_o, rvalid_o;
   logic [NW*TW-1:0] rtag_o;
   logic [NW*3-1:0] rstate_o;
   logic [NW-1:0]   hit_way_o;
   logic            hit_o, multi_hit_o, inv_busy_o, inv_done_o;

   always #5 clk = ~clk;

   dcache_tag_arbiter_mp dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .set_i(set_v),
      .way_we_i(way_we), .wtag_i(wtag), .wstate_i(wstate), .cmp_tag_i(cmp),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rtag_o(rtag_o), .rstate_o(rstate_o),
      .hit_way_o(hit_way_o), .hit_o(hit_o), .multi_hit_o(multi_hit_o),
      .inv_all_i(inv_all), .inv_busy_o(inv_busy_o), .inv_done_o(inv_done_o)
   );

   typedef struct packed {
      logic [NP-1:0]    rv;
      logic [NW-1:0]    hit;
      logic             hit1;
      logic             multi;
      logic [NW*3-1:0]  st;
      logic [NW*TW-1:0] tag;
      logic [NW*TW-1:0] tmask;
   } exp_t;

   exp_t           q[$];
   logic [TW-1:0]  tag_m [NSETS][NW];
   logic [2:0]     st_m  [NSETS][NW];
   bit             known [NSETS][NW];
   int             rem, rr;
   int             checks = 0, failures = 0, done_seen = 0;

   task automatic chk(input string name, input logic [NW*TW-1:0] act, input logic [NW*TW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void clear_states();
      for (int s = 0; s < NSETS; s++)
         for (int w = 0; w < NW; w++) st_m[s][w] = 3'b000;
   endfunction

   function automatic logic [NP-1:0] arb(input logic [NP-1:0] r);
      for (int i = 0; i < PRIO; i++) if (r[i]) return NP'(1) << i;
      for (int k = 0; k < NP - PRIO; k++) begin
         int p = PRIO + (rr - PRIO + k) % (NP - PRIO);
         if (r[p]) return NP'(1) << p;
      end
      return '0;
   endfunction

   // Monitor / reference model: checks this cycle, then advances the model by one edge.
   initial begin
      logic [NP-1:0] eg;
      exp_t e;
      int win, s;
      logic [TW-1:0] c;
      rem = NSETS; rr = PRIO; clear_states();
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("inv_busy", NW*TW'(inv_busy_o), NW*TW'(rem > 0));
         chk("inv_done", NW*TW'(inv_done_o), NW*TW'(rem == 1));
         if (inv_done_o) done_seen++;
         eg = (rem > 0 || inv_all) ? '0 : arb(req);
         chk("gnt", NW*TW'(gnt_o), NW*TW'(eg));
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rvalid", NW*TW'(rvalid_o), NW*TW'(e.rv));
            chk("hit_way", NW*TW'(hit_way_o), NW*TW'(e.hit));
            chk("hit", NW*TW'(hit_o), NW*TW'(e.hit1));
            chk("multi_hit", NW*TW'(multi_hit_o), NW*TW'(e.multi));
            chk("rstate", NW*TW'(rstate_o), NW*TW'(e.st));
            chk("rtag", rtag_o & e.tmask, e.tag & e.tmask);
         end else begin
            chk("rvalid_idle", NW*TW'(rvalid_o), '0);
         end
         if (rst) begin
            rem = NSETS; rr = PRIO; clear_states(); q.delete();
         end else if (rem > 0) begin
            rem--;
         end else if (inv_all) begin
            rem = NSETS; clear_states();
         end else if (eg != '0) begin
            win = 0;
            for (int p = 0; p < NP; p++) if (eg[p]) win = p;
            if (win >= PRIO) rr = (win + 1 < NP) ? win + 1 : PRIO;
            s = int'(set_v[win*SW +: SW]);
            if (we[win]) begin
               for (int w = 0; w < NW; w++) if (way_we[win*NW + w]) begin
                  tag_m[s][w] = wtag[win*TW +: TW];
                  st_m[s][w]  = wstate[win*3 +: 3];
                  known[s][w] = 1'b1;
               end
            end else begin
               c = cmp[win*TW +: TW];
               e = '0;
               e.rv = eg;
               for (int w = 0; w < NW; w++) begin
                  e.st[w*3 +: 3] = st_m[s][w];
                  if (known[s][w]) begin
                     e.tag[w*TW +: TW]   = tag_m[s][w];
                     e.tmask[w*TW +: TW] = '1;
                     e.hit[w] = st_m[s][w][0] && (tag_m[s][w] == c);
                  end
               end
               e.hit1  = |e.hit;
               e.multi = $countones(e.hit) > 1;
               q.push_back(e);
            end
         end
      end
   end

   // Advance one cycle and drop requests that were granted in it.
   task automatic step();
      logic [NP-1:0] g;
      @(negedge clk);
      g = gnt_o;
      @(posedge clk);
      #1;
      req = req & ~g;
   endtask

   task automatic set_port(input int p, input bit w, input int s, input logic [NW-1:0] wm,
                           input logic [TW-1:0] t, input logic [2:0] st, input logic [TW-1:0] c);
      we[p]              = w;
      set_v[p*SW +: SW]  = SW'(s);
      way_we[p*NW +: NW] = wm;
      wtag[p*TW +: TW]   = t;
      wstate[p*3 +: 3]   = st;
      cmp[p*TW +: TW]    = c;
      req[p]             = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 800 && req != '0; n++) step();
      if (req != '0) begin
         checks++; failures++;
         $display("FAIL %s_timeout actual=%0h required=0", name, req);
         req = '0;
      end
   endtask

   task automatic op(input int p, input bit w, input int s, input logic [NW-1:0] wm,
                     input logic [TW-1:0] t, input logic [2:0] st, input logic [TW-1:0] c);
      set_port(p, w, s, wm, t, st, c);
      drain("op");
   endtask

   task automatic rand_phase(input int n, input int inv_at);
      for (int i = 0; i < n; i++) begin
         step();
         inv_all = (i == inv_at);
         for (int p = 0; p < NP; p++)
            if (!req[p] && $urandom_range(0, 2) == 0)
               set_port(p, 1'($urandom), $urandom_range(0, 3), NW'($urandom),
                        TW'($urandom_range(1, 3)), 3'($urandom), TW'($urandom_range(1, 3)));
      end
      step();
      inv_all = 1'b0;
   endtask

   initial begin
      int d0;
      rst = 1'b1; inv_all = 1'b0; req = '0; we = '0; set_v = '0; way_we = '0;
      wtag = '0; wstate = '0; cmp = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      // All ports request throughout the reset sweep; nothing may be granted.
      for (int p = 0; p < NP; p++) set_port(p, 1'b0, p, '0, '0, '0, TW'(p));
      repeat (256) step();
      drain("post_reset");
      for (int s = 0; s < NSETS; s++) op(0, 1'b0, s, '0, '0, '0, TW'($urandom));
      // Fixed priority between ports 0/1 over round-robin port 3.
      set_port(0, 1'b0, 1, '0, '0, '0, 1);
      set_port(1, 1'b0, 2, '0, '0, '0, 2);
      set_port(3, 1'b0, 3, '0, '0, '0, 3);
      drain("prio");
      // Continuous round-robin requesters 2, 3, 4.
      for (int p = 2; p < NP; p++) set_port(p, 1'b0, p, '0, '0, '0, TW'(p));
      for (int k = 0; k < 6; k++) begin
         step();
         for (int p = 2; p < NP; p++) if (!req[p]) set_port(p, 1'b0, p, '0, '0, '0, TW'(p));
      end
      drain("rr");
      op(2, 1'b1, 'h15, 8'b0000_1000, 44'hABC, 3'b001, '0);
      op(4, 1'b0, 'h15, '0, '0, '0, 44'hABC);
      op(1, 1'b1, 7, 8'b0010_0010, 44'h55, 3'b001, '0);
      op(3, 1'b0, 7, '0, '0, '0, 44'h55);
      rand_phase(400, 50);
      drain("rand1");
      op(4, 1'b0, 'h15, '0, '0, '0, 44'hABC);
      op(3, 1'b0, 7, '0, '0, '0, 44'h55);
      // Reset in the middle of a sweep restarts it; exactly one completion pulse.
      inv_all = 1'b1;
      step();
      inv_all = 1'b0;
      repeat (100) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      d0 = done_seen;
      repeat (300) step();
      chk("done_pulses", NW*TW'(done_seen - d0), NW*TW'(1));
      rand_phase(1500, 700);
      drain("rand2");
      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
